// File: rtl/bullet_fire_ctrl.sv
// bullet_fire_ctrl
// Turns keyboard input into single-frame fire requests for the bullet block,
// latches the travel direction at launch, and follows the bullet in flight
// until it hits the enemy, leaves the screen or times out. A cooldown then
// holds off the next shot.

module bullet_fire_ctrl #(
    parameter int HIT_RADIUS      = 8,
    parameter int EDGE_MARGIN     = 4,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int FLIGHT_MAX      = 700
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] BulletX,
    input  logic [9:0] BulletY,
    input  logic [9:0] EnemyX,
    input  logic [9:0] EnemyY,
    output logic       shoot,
    output logic [1:0] Direction,
    output logic       bullet_active,
    output logic       hit,
    output logic [7:0] score
);

    // USB HID keycodes of interest
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Direction encodings shared by facing and Direction
    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    // Geometry and timing limits folded into 10-bit constants so every
    // compare below is a plain unsigned 10-bit compare
    localparam logic [9:0] RADIUS        = 10'(HIT_RADIUS);
    localparam logic [9:0] LEFT_EDGE     = 10'(EDGE_MARGIN);
    localparam logic [9:0] RIGHT_EDGE    = 10'(X_MAX - EDGE_MARGIN);
    localparam logic [9:0] TOP_EDGE      = 10'(EDGE_MARGIN);
    localparam logic [9:0] BOTTOM_EDGE   = 10'(Y_MAX - EDGE_MARGIN);
    localparam logic [9:0] FLIGHT_LAST   = 10'(FLIGHT_MAX - 1);
    localparam logic [9:0] COOLDOWN_LOAD = 10'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        FLIGHT,
        COOLDOWN
    } state_t;

    state_t     state;
    logic [7:0] prev_key;
    logic [1:0] facing;
    logic [9:0] flight_cnt;
    logic [9:0] cool_cnt;

    logic       fire_edge;
    logic [9:0] dist_x;
    logic [9:0] dist_y;
    logic       hit_now;
    logic       edge_now;
    logic       timeout_now;

    // Space counts only on the frame it goes down, so holding it fires once
    assign fire_edge = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);

    // Per-axis distances are larger minus smaller so they never wrap
    always_comb begin
        dist_x = 10'd0;
        dist_y = 10'd0;
        if (BulletX >= EnemyX) dist_x = BulletX - EnemyX;
        else                   dist_x = EnemyX - BulletX;
        if (BulletY >= EnemyY) dist_y = BulletY - EnemyY;
        else                   dist_y = EnemyY - BulletY;
    end

    // Flight-ending conditions, prioritised later inside the FSM
    assign hit_now     = (dist_x <= RADIUS) && (dist_y <= RADIUS);
    assign edge_now    = (BulletX <= LEFT_EDGE) || (BulletX >= RIGHT_EDGE) ||
                         (BulletY <= TOP_EDGE)  || (BulletY >= BOTTOM_EDGE);
    assign timeout_now = (flight_cnt == FLIGHT_LAST);

    // Remember last frame's keycode for space-press edge detection
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) prev_key <= 8'h00;
        else       prev_key <= keycode;
    end

    // Facing follows the WASD keys in every state; other keys leave it alone
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            facing <= DIR_RIGHT;
        end else begin
            case (keycode)
                KEY_A:   facing <= DIR_LEFT;
                KEY_D:   facing <= DIR_RIGHT;
                KEY_S:   facing <= DIR_DOWN;
                KEY_W:   facing <= DIR_UP;
                default: facing <= facing;
            endcase
        end
    end

    // Shot sequencer: launch, track flight, then cool down before re-arming
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            shoot         <= 1'b0;
            Direction     <= DIR_RIGHT;
            bullet_active <= 1'b0;
            hit           <= 1'b0;
            score         <= 8'd0;
            flight_cnt    <= 10'd0;
            cool_cnt      <= 10'd0;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_edge) begin
                        state         <= LAUNCH;
                        shoot         <= 1'b1;
                        Direction     <= facing;
                        bullet_active <= 1'b1;
                        flight_cnt    <= 10'd0;
                    end
                end
                LAUNCH: begin
                    state <= FLIGHT;
                    shoot <= 1'b0;
                end
                FLIGHT: begin
                    flight_cnt <= flight_cnt + 10'd1;
                    if (hit_now) begin
                        hit           <= 1'b1;
                        if (score != 8'hFF) score <= score + 8'd1;
                        state         <= COOLDOWN;
                        bullet_active <= 1'b0;
                        cool_cnt      <= COOLDOWN_LOAD;
                    end else if (edge_now || timeout_now) begin
                        state         <= COOLDOWN;
                        bullet_active <= 1'b0;
                        cool_cnt      <= COOLDOWN_LOAD;
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt <= 10'd1) state <= IDLE;
                    else                   cool_cnt <= cool_cnt - 10'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// tb_bullet_fire_ctrl
// Drives keycodes and bullet/enemy positions frame by frame. A timing-level
// reference model predicts shoot and flight-end events into a queue; an
// independent monitor pops and compares them when the DUT produces them.

module tb_bullet_fire_ctrl;

    localparam int HIT_RADIUS      = 8;
    localparam int EDGE_MARGIN     = 4;
    localparam int X_MAX           = 639;
    localparam int Y_MAX           = 479;
    localparam int COOLDOWN_FRAMES = 15;
    localparam int FLIGHT_MAX      = 700;

    localparam int KIND_SHOOT = 0;
    localparam int KIND_END   = 1;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] BulletX;
    logic [9:0] BulletY;
    logic [9:0] EnemyX;
    logic [9:0] EnemyY;
    logic       shoot;
    logic [1:0] Direction;
    logic       bullet_active;
    logic       hit;
    logic [7:0] score;

    bullet_fire_ctrl #(
        .HIT_RADIUS(HIT_RADIUS),
        .EDGE_MARGIN(EDGE_MARGIN),
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .FLIGHT_MAX(FLIGHT_MAX)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .keycode(keycode),
        .BulletX(BulletX),
        .BulletY(BulletY),
        .EnemyX(EnemyX),
        .EnemyY(EnemyY),
        .shoot(shoot),
        .Direction(Direction),
        .bullet_active(bullet_active),
        .hit(hit),
        .score(score)
    );

    // Free-running frame clock
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int kind;
        int cyc;
        int dir;
        int hit;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: event timing in absolute frame numbers
    int         m_facing;
    int         m_dir;
    int         m_score;
    int         m_launch;
    int         m_ready;
    bit         m_in_flight;
    logic [7:0] m_last_key;

    logic [7:0] key_pool [10] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h07,
                                  8'h16, 8'h1A, 8'h2C, 8'h2C, 8'h11};

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic modelReset();
        m_facing    = 1;
        m_dir       = 1;
        m_score     = 0;
        m_launch    = 0;
        m_ready     = 0;
        m_in_flight = 1'b0;
        m_last_key  = 8'h00;
    endtask

    // Called at a negedge: drive one frame, predict it, return at next negedge
    task automatic applyStimulus(input logic [7:0] key, input int bx, input int by,
                                 input int ex, input int ey);
        int   f;
        int   dx;
        int   dy;
        bit   fire;
        bit   is_hit;
        bit   is_edge;
        bit   is_timeout;
        exp_t e;
        keycode = key;
        BulletX = 10'(bx);
        BulletY = 10'(by);
        EnemyX  = 10'(ex);
        EnemyY  = 10'(ey);
        f    = cycle + 1;
        fire = (key == 8'h2C) && (m_last_key != 8'h2C);
        if (!m_in_flight) begin
            if (fire && f >= m_ready) begin
                m_in_flight = 1'b1;
                m_launch    = f;
                m_dir       = m_facing;
                e = '{kind: KIND_SHOOT, cyc: f, dir: m_dir, hit: 0, score: 0};
                exp_q.push_back(e);
            end
        end else if (f >= m_launch + 2) begin
            dx = (bx > ex) ? bx - ex : ex - bx;
            dy = (by > ey) ? by - ey : ey - by;
            is_hit     = (dx <= HIT_RADIUS) && (dy <= HIT_RADIUS);
            is_edge    = (bx <= EDGE_MARGIN) || (bx >= X_MAX - EDGE_MARGIN) ||
                         (by <= EDGE_MARGIN) || (by >= Y_MAX - EDGE_MARGIN);
            is_timeout = (f - m_launch - 2) == FLIGHT_MAX - 1;
            if (is_hit || is_edge || is_timeout) begin
                if (is_hit && m_score < 255) m_score++;
                e = '{kind: KIND_END, cyc: f, dir: m_dir, hit: int'(is_hit), score: m_score};
                exp_q.push_back(e);
                m_in_flight = 1'b0;
                m_ready     = f + COOLDOWN_FRAMES + 1;
            end
        end
        case (key)
            8'h04:   m_facing = 0;
            8'h07:   m_facing = 1;
            8'h16:   m_facing = 2;
            8'h1A:   m_facing = 3;
            default: m_facing = m_facing;
        endcase
        m_last_key = key;
        @(negedge frame_clk);
    endtask

    task automatic idleFrames(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 320, 240, 100, 100);
    endtask

    // Fire, launch, then put the bullet on the enemy
    task automatic quickHit();
        idleFrames(17);
        applyStimulus(8'h2C, 320, 240, 100, 100);
        applyStimulus(8'h00, 320, 240, 100, 100);
        applyStimulus(8'h00, 100, 100, 100, 100);
    endtask

    task automatic doReset(input string tag);
        Reset   = 1'b1;
        keycode = 8'h00;
        exp_q.delete();
        modelReset();
        #1;
        checkOutput({tag, "_shoot"}, int'(shoot), 0);
        checkOutput({tag, "_direction"}, int'(Direction), 1);
        checkOutput({tag, "_active"}, int'(bullet_active), 0);
        checkOutput({tag, "_hit"}, int'(hit), 0);
        checkOutput({tag, "_score"}, int'(score), 0);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    // Monitor: sample after each rising edge and match DUT events to the queue
    initial begin : monitor
        exp_t e;
        bit   prev_active;
        prev_active = 1'b0;
        forever begin
            @(posedge frame_clk);
            cycle++;
            #1;
            if (Reset) begin
                prev_active = 1'b0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missed_event: kind %0d due at cycle %0d, not observed by cycle %0d",
                             e.kind, e.cyc, cycle);
                end
                if (shoot) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_shoot: shoot=1 at cycle %0d, none required", cycle);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("shoot_kind", KIND_SHOOT, e.kind);
                        checkOutput("shoot_cycle", cycle, e.cyc);
                        checkOutput("shoot_direction", int'(Direction), e.dir);
                        checkOutput("shoot_active", int'(bullet_active), 1);
                        checkOutput("shoot_hit", int'(hit), 0);
                    end
                end else if (prev_active && !bullet_active) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_end: flight ended at cycle %0d, none required", cycle);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("end_kind", KIND_END, e.kind);
                        checkOutput("end_cycle", cycle, e.cyc);
                        checkOutput("end_hit", int'(hit), e.hit);
                        checkOutput("end_score", int'(score), e.score);
                        checkOutput("end_direction", int'(Direction), e.dir);
                    end
                end else begin
                    checkOutput("no_stray_hit", int'(hit), 0);
                    checkOutput("active_steady", int'(bullet_active), int'(prev_active));
                end
                prev_active = bullet_active;
            end
        end
    end

    // Stimulus: directed scenarios, a randomized phase, then reset/saturation
    initial begin : driver
        int ex;
        int ey;
        int bx;
        int by;
        int sel;
        Reset   = 1'b1;
        keycode = 8'h00;
        BulletX = 10'd320;
        BulletY = 10'd240;
        EnemyX  = 10'd100;
        EnemyY  = 10'd100;
        doReset("reset");

        $display("[TB] held space gives a single shot facing right");
        applyStimulus(8'h07, 320, 240, 100, 100);
        repeat (5) applyStimulus(8'h2C, 320, 240, 100, 100);
        idleFrames(3);

        $display("[TB] left-edge exit, early press ignored, press after cooldown fires");
        applyStimulus(8'h00, 3, 240, 100, 100);
        idleFrames(4);
        applyStimulus(8'h2C, 320, 240, 100, 100);
        idleFrames(10);
        applyStimulus(8'h2C, 320, 240, 100, 100);
        idleFrames(3);
        applyStimulus(8'h00, 320, 3, 100, 100);
        idleFrames(20);

        $display("[TB] upward shot hits enemy, facing change mid-flight ignored");
        applyStimulus(8'h1A, 320, 240, 300, 200);
        applyStimulus(8'h00, 320, 240, 300, 200);
        applyStimulus(8'h2C, 320, 240, 300, 200);
        applyStimulus(8'h00, 320, 100, 300, 200);
        applyStimulus(8'h04, 320, 100, 300, 200);
        applyStimulus(8'h04, 309, 206, 300, 200);
        applyStimulus(8'h00, 305, 206, 300, 200);
        idleFrames(20);

        $display("[TB] hit and right edge in the same frame");
        applyStimulus(8'h2C, 320, 240, 632, 240);
        applyStimulus(8'h00, 320, 240, 632, 240);
        applyStimulus(8'h00, 636, 240, 632, 240);
        idleFrames(20);

        $display("[TB] frozen bullet times out");
        applyStimulus(8'h2C, 320, 240, 100, 100);
        idleFrames(710);
        idleFrames(20);

        $display("[TB] randomized frames");
        ex = 300;
        ey = 200;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                ex = int'($urandom_range(580, 40));
                ey = int'($urandom_range(420, 40));
            end
            sel = int'($urandom_range(15, 0));
            if (sel < 3) begin
                bx = ex + int'($urandom_range(20, 0)) - 10;
                by = ey + int'($urandom_range(20, 0)) - 10;
            end else if (sel == 3) begin
                bx = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8, 0)) : int'($urandom_range(639, 631));
                by = int'($urandom_range(400, 80));
            end else if (sel == 4) begin
                bx = int'($urandom_range(560, 80));
                by = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8, 0)) : int'($urandom_range(479, 471));
            end else begin
                bx = int'($urandom_range(620, 20));
                by = int'($urandom_range(460, 20));
            end
            applyStimulus(key_pool[$urandom_range(9, 0)], bx, by, ex, ey);
        end

        $display("[TB] reset asserted mid-flight with score 3");
        doReset("prep");
        repeat (3) quickHit();
        idleFrames(17);
        applyStimulus(8'h1A, 320, 240, 100, 100);
        applyStimulus(8'h2C, 320, 240, 100, 100);
        applyStimulus(8'h00, 320, 240, 100, 100);
        applyStimulus(8'h00, 320, 240, 100, 100);
        applyStimulus(8'h00, 320, 240, 100, 100);
        doReset("midflight");
        applyStimulus(8'h2C, 320, 240, 100, 100);
        applyStimulus(8'h00, 320, 240, 100, 100);
        applyStimulus(8'h00, 2, 240, 100, 100);

        $display("[TB] score saturation");
        doReset("presat");
        repeat (257) quickHit();

        for (int i = 0; i < 800 && exp_q.size() > 0; i++) idleFrames(1);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d events still pending, 0 required", exp_q.size());
        end
        idleFrames(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bullet_fire_ctrl.md
# bullet_fire_ctrl

Initiator side of the bullet interface: turns keyboard input into single-frame `shoot` pulses plus a latched `Direction` for the bullet block, then tracks the bullet in flight. Watches the returned bullet position for screen-edge exit, enemy hit or timeout, and enforces a cooldown before the next shot. Runs on the frame clock between the USB keycode path and the bullet and scoring logic.

## Interface
- `HIT_RADIUS`, 8: max per-axis distance (pixels) between bullet and enemy centres that counts as a hit.
- `EDGE_MARGIN`, 4: distance from a screen border at which the bullet is considered gone.
- `X_MAX`, 639: rightmost pixel column.
- `Y_MAX`, 479: bottom pixel row.
- `COOLDOWN_FRAMES`, 15: frames spent in COOLDOWN after a flight ends.
- `FLIGHT_MAX`, 700: maximum frames in FLIGHT before a forced end.
- `frame_clk` input 1: frame clock; all state changes on its rising edge.
- `Reset` input 1: reset, asynchronous, active-high; clock `frame_clk`.
- `keycode` input 8: current USB HID keycode (0x00 = none).
- `BulletX`, `BulletY` input 10 each: bullet centre position from the bullet block.
- `EnemyX`, `EnemyY` input 10 each: enemy centre position.
- `shoot` output 1: one-frame fire request to the bullet block.
- `Direction` output 2: travel direction. 00 = left (X−1), 01 = right (X+1), 10 = down (Y+1), 11 = up (Y−1).
- `bullet_active` output 1: high during LAUNCH and FLIGHT.
- `hit` output 1: one-frame pulse when the enemy is hit.
- `score` output 8: saturating hit count.

## Operation
- Facing register, updated in every state from the keycode:
  - A (0x04) → 00; D (0x07) → 01; S (0x16) → 10; W (0x1A) → 11.
  - Any other keycode leaves it unchanged.
- Fire edge: `keycode`==0x2C this frame and the registered previous keycode ≠ 0x2C.
  - Holding space fires only once; the key must be released before the next fire edge.
- FSM states IDLE, LAUNCH, FLIGHT, COOLDOWN.
  - IDLE: on a fire edge → LAUNCH. Set `shoot`=1, `Direction`←facing, `bullet_active`=1, clear the flight counter.
  - LAUNCH: exactly one frame. Then → FLIGHT, `shoot`=0.
  - FLIGHT: increment the flight counter every frame. Evaluate in this priority order:
    - Hit when |BulletX−EnemyX| ≤ HIT_RADIUS and |BulletY−EnemyY| ≤ HIT_RADIUS. Then `hit`=1 for one frame, `score`+1 (saturates at 255), → COOLDOWN.
    - Edge when BulletX ≤ EDGE_MARGIN, BulletX ≥ X_MAX−EDGE_MARGIN, BulletY ≤ EDGE_MARGIN, or BulletY ≥ Y_MAX−EDGE_MARGIN. Then → COOLDOWN.
    - Timeout when the flight counter reaches FLIGHT_MAX−1. Then → COOLDOWN.
  - Entering COOLDOWN: `bullet_active`=0, load the cooldown counter.
  - COOLDOWN: count COOLDOWN_FRAMES frames, then → IDLE. With COOLDOWN_FRAMES=0, return to IDLE on the next edge.
- Fire edges in LAUNCH, FLIGHT or COOLDOWN are discarded, not queued.
- `Direction` holds its launch value from LAUNCH until the next LAUNCH; facing changes mid-flight do not affect it.
- Arithmetic rules:
  - Absolute differences are computed unsigned in 10 bits as larger minus smaller; no wrap.
  - Edge compares are unsigned against 10-bit constants.
  - Counters are 10 bits; the score is 8 bits.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- Reset values: state IDLE, `shoot`=0, `Direction`=01, facing=01, `bullet_active`=0, `hit`=0, `score`=0, previous keycode=0x00, counters 0.
- Fire latency: a fire edge sampled at edge N gives `shoot`=1 from N to N+1; `shoot` returns to 0 at N+1.
- The first hit/edge/timeout evaluation happens at edge N+2.
- Flight end: the condition sampled at edge M gives `hit` (if a hit) and `bullet_active`=0 from edge M; `hit` clears at M+1.
- Re-fire: the earliest next `shoot` is COOLDOWN_FRAMES+1 edges after M, and needs a fresh fire edge.
- Simultaneous hit and edge in the same frame: the hit wins; score increments once.
- At score=255 a further hit still pulses `hit`; the score stays 255.
- Reset asserted mid-flight: all state returns to reset values immediately, with no `hit` pulse.

## Test plan
- Reset, then keycode 0x07 for one frame, then 0x2C held for 5 frames → exactly one `shoot` pulse, one frame long, with `Direction`=01; `bullet_active` rises with `shoot`.
- Launch with facing 11; EnemyX/Y=(300,200), bullet stepped to (305,206) in FLIGHT → `hit` one frame, `score`=1, `bullet_active`=0, and `Direction` stays 11 even if 0x04 is pressed mid-flight.
- Bullet at BulletX=3 in FLIGHT → COOLDOWN without a hit. A new space press 5 frames later produces no `shoot`. A press after 16 frames produces `shoot`.
- Bullet at (636,240) with the enemy at (632,240) in the same frame → `hit`=1, `score`+1 exactly once.
- Bullet frozen mid-screen → flight ends after 700 FLIGHT frames with `bullet_active`=0 and no `hit`. Separately, preload 255 hits → a further hit pulses `hit` and `score` stays 255.
- Assert Reset during FLIGHT with `score`=3 → all outputs immediately at reset values (`score`=0, `Direction`=01, state IDLE).
